platform_line_renderer: RTL and testbench

- Reads the 16-bit-wide platform tile ROM (4 rows per tile code; codes 00 = left cap, 01 = middle, 02 = right cap) and converts a list of platforms into per-pixel coverage for the VGA colour mapper.
- Double-buffered one-line store: while line Y is displayed, the FSM fetches ROM rows for line Y+1 into the other buffer.
- Sits between the game-state registers (platform positions) and the colour mapper; drives the ROM's address port.

---
 rtl/platform_line_renderer.sv | 176 +++++++++++++++++
 tb/tb_platform_line_renderer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/platform_line_renderer.sv
// Platform line renderer: fetches tile-ROM rows for the next scanline into one
// half of a double-buffered line store while the other half drives plat_on.
module platform_line_renderer #(
    parameter int NUM_PLAT       = 4,
    parameter int VLINES         = 525,
    parameter int TILES_PER_LINE = 40
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  line_start,
    input  logic [9:0]            DrawX,
    input  logic [9:0]            DrawY,
    input  logic [NUM_PLAT-1:0]   plat_en,
    input  logic [6*NUM_PLAT-1:0] plat_tx,
    input  logic [10*NUM_PLAT-1:0] plat_y,
    input  logic [4*NUM_PLAT-1:0] plat_len,
    output logic [10:0]           rom_addr,
    input  logic [15:0]           rom_data,
    output logic                  plat_on,
    output logic                  busy,
    output logic                  overrun
);

    localparam int SW = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1;

    typedef enum logic [1:0] {IDLE, CLEAR, SCAN, FETCH} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   slot_q, slot_d;
    logic [3:0]      tile_q, tile_d;
    logic [1:0]      row_q, row_d;
    logic [9:0]      target_y_q;
    logic            disp_sel_q;
    logic [10:0]     rom_addr_q;
    logic            overrun_q;
    logic            plat_on_q;
    logic [15:0]     bank_q [2][TILES_PER_LINE];

    // Per-slot views of the packed platform buses.
    logic       en_s  [NUM_PLAT];
    logic [5:0] tx_s  [NUM_PLAT];
    logic [9:0] y_s   [NUM_PLAT];
    logic [3:0] len_s [NUM_PLAT];

    for (genvar gi = 0; gi < NUM_PLAT; gi++) begin : g_slot
        assign en_s[gi]  = plat_en[gi];
        assign tx_s[gi]  = plat_tx[6*gi +: 6];
        assign y_s[gi]   = plat_y[10*gi +: 10];
        assign len_s[gi] = plat_len[4*gi +: 4];
    end

    logic       cur_en;
    logic [5:0] cur_tx;
    logic [9:0] cur_y;
    logic [3:0] cur_len;
    logic [9:0] scan_row;
    logic       scan_hit;
    logic       last_slot;
    logic       tile_last;
    logic [1:0] fetch_code;
    logic [6:0] fetch_idx;
    logic       fetch_wr;
    logic       fill_sel;
    logic       in_active;

    assign cur_en    = en_s[slot_q];
    assign cur_tx    = tx_s[slot_q];
    assign cur_y     = y_s[slot_q];
    assign cur_len   = len_s[slot_q];
    assign scan_row  = target_y_q - cur_y;
    assign scan_hit  = cur_en && (cur_len != 4'd0) && (scan_row < 10'd4);
    assign last_slot = (slot_q == SW'(NUM_PLAT - 1));
    // A length shrunk to zero mid-fill must still terminate the slot.
    assign tile_last = (cur_len == 4'd0) || (tile_q >= cur_len - 4'd1);
    assign fetch_idx = {1'b0, cur_tx} + {3'b000, tile_q};
    assign fetch_wr  = (fetch_idx < 7'(TILES_PER_LINE));
    assign fill_sel  = ~disp_sel_q;
    assign in_active = (DrawX < 10'(TILES_PER_LINE * 16)) && (DrawY < 10'd480);

    always_comb begin
        fetch_code = 2'd1;
        if (cur_len == 4'd1)
            fetch_code = 2'd1;
        else if (tile_q == 4'd0)
            fetch_code = 2'd0;
        else if (tile_q == cur_len - 4'd1)
            fetch_code = 2'd2;
    end

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        tile_d   = tile_q;
        row_d    = row_q;
        rom_addr = rom_addr_q;
        if (state_q == FETCH)
            rom_addr = {7'd0, fetch_code, row_q};
        if (line_start) begin
            state_d = CLEAR;
            slot_d  = '0;
        end else begin
            case (state_q)
                IDLE: ;
                CLEAR: begin
                    state_d = SCAN;
                    slot_d  = '0;
                end
                SCAN: begin
                    if (scan_hit) begin
                        state_d = FETCH;
                        tile_d  = 4'd0;
                        row_d   = scan_row[1:0];
                    end else if (last_slot) begin
                        state_d = IDLE;
                    end else begin
                        slot_d = slot_q + SW'(1);
                    end
                end
                FETCH: begin
                    if (tile_last) begin
                        if (last_slot) begin
                            state_d = IDLE;
                        end else begin
                            state_d = SCAN;
                            slot_d  = slot_q + SW'(1);
                        end
                    end else begin
                        tile_d = tile_q + 4'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            slot_q     <= '0;
            tile_q     <= '0;
            row_q      <= '0;
            target_y_q <= '0;
            disp_sel_q <= 1'b0;
            rom_addr_q <= '0;
            overrun_q  <= 1'b0;
            plat_on_q  <= 1'b0;
            for (int b = 0; b < 2; b++)
                for (int w = 0; w < TILES_PER_LINE; w++)
                    bank_q[b][w] <= '0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            tile_q     <= tile_d;
            row_q      <= row_d;
            rom_addr_q <= rom_addr;
            plat_on_q  <= in_active ? bank_q[disp_sel_q][DrawX[9:4]][~DrawX[3:0]] : 1'b0;
            if (line_start) begin
                disp_sel_q <= ~disp_sel_q;
                target_y_q <= (DrawY == 10'(VLINES - 1)) ? 10'd0 : DrawY + 10'd1;
                if (state_q != IDLE)
                    overrun_q <= 1'b1;
            end else if (state_q == CLEAR) begin
                for (int w = 0; w < TILES_PER_LINE; w++)
                    bank_q[fill_sel][w] <= '0;
            end else if (state_q == FETCH && fetch_wr) begin
                // Writes on a line_start cycle are suppressed: that bank is now on display.
                bank_q[fill_sel][fetch_idx[5:0]] <= bank_q[fill_sel][fetch_idx[5:0]] | rom_data;
            end
        end
    end

    assign plat_on = plat_on_q;
    assign busy    = (state_q != IDLE);
    assign overrun = overrun_q;

endmodule

// File: tb/tb_platform_line_renderer.sv
// Bench for platform_line_renderer: directed scenarios plus randomized platform
// sets, checked per cycle (rom_addr/busy) and per pixel (plat_on) against a model.
module tb_platform_line_renderer;

    localparam int NP = 4;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          line_start;
    logic [9:0]    DrawX;
    logic [9:0]    DrawY;
    logic [NP-1:0] plat_en;
    logic [6*NP-1:0]  plat_tx;
    logic [10*NP-1:0] plat_y;
    logic [4*NP-1:0]  plat_len;
    logic [10:0]   rom_addr;
    logic [15:0]   rom_data;
    logic          plat_on;
    logic          busy;
    logic          overrun;

    bit   p_en  [NP];
    int   p_tx  [NP];
    int   p_y   [NP];
    int   p_len [NP];
    logic [15:0] rom_mem [12];

    int errors = 0;
    int checks = 0;
    logic [10:0] last_addr;
    logic [10:0] ea [$];
    logic [15:0] exp_line [40];
    logic [15:0] obs_line [40];

    platform_line_renderer #(.NUM_PLAT(NP), .VLINES(525), .TILES_PER_LINE(40)) dut (
        .Clk(Clk), .Reset(Reset), .line_start(line_start), .DrawX(DrawX), .DrawY(DrawY),
        .plat_en(plat_en), .plat_tx(plat_tx), .plat_y(plat_y), .plat_len(plat_len),
        .rom_addr(rom_addr), .rom_data(rom_data), .plat_on(plat_on), .busy(busy),
        .overrun(overrun)
    );

    always #5 Clk = ~Clk;

    always_comb begin
        plat_en  = '0;
        plat_tx  = '0;
        plat_y   = '0;
        plat_len = '0;
        for (int i = 0; i < NP; i++) begin
            plat_en[i]         = p_en[i];
            plat_tx[6*i +: 6]  = p_tx[i][5:0];
            plat_y[10*i +: 10] = p_y[i][9:0];
            plat_len[4*i +: 4] = p_len[i][3:0];
        end
    end

    assign rom_data = (rom_addr < 11'd12) ? rom_mem[rom_addr[3:0]] : 16'h0000;

    function automatic int tgt_of(input int y);
        return (y == 524) ? 0 : y + 1;
    endfunction

    function automatic int code_of(input int t, input int len);
        if (len == 1) return 1;
        if (t == 0) return 0;
        if (t == len - 1) return 2;
        return 1;
    endfunction

    function automatic int row_of(input int tgt, input int s);
        return (tgt - p_y[s] + 1024) % 1024;
    endfunction

    function automatic bit hits(input int tgt, input int s);
        return p_en[s] && p_len[s] != 0 && row_of(tgt, s) < 4;
    endfunction

    // Expected line contents: every tile of every visible platform row, ORed in.
    function automatic void model_line(input int tgt);
        for (int w = 0; w < 40; w++) exp_line[w] = 16'h0;
        for (int s = 0; s < NP; s++) begin
            if (hits(tgt, s)) begin
                for (int t = 0; t < p_len[s]; t++) begin
                    if (p_tx[s] + t < 40)
                        exp_line[p_tx[s] + t] |= rom_mem[code_of(t, p_len[s]) * 4 + row_of(tgt, s)];
                end
            end
        end
    endfunction

    // Expected rom_addr per busy cycle: one CLEAR, one SCAN per slot, one FETCH per tile.
    function automatic void build_trace(input int tgt);
        logic [10:0] a;
        a = last_addr;
        ea.delete();
        ea.push_back(a);
        for (int s = 0; s < NP; s++) begin
            ea.push_back(a);
            if (hits(tgt, s)) begin
                for (int t = 0; t < p_len[s]; t++) begin
                    a = 11'(code_of(t, p_len[s]) * 4 + row_of(tgt, s));
                    ea.push_back(a);
                end
            end
        end
    endfunction

    task automatic pulse_ls(input int y);
        DrawY = 10'(y);
        line_start = 1'b1;
        @(posedge Clk); #1;
        line_start = 1'b0;
    endtask

    task automatic check_trace(input int tgt, input int ncheck, input string tag);
        int n;
        build_trace(tgt);
        n = (ncheck < 0) ? ea.size() : ncheck;
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin @(posedge Clk); #1; end
            checks += 2;
            if (rom_addr !== ea[k]) begin
                errors++;
                $display("FAIL %s rom_addr cyc%0d: got %0d expected %0d", tag, k, rom_addr, ea[k]);
            end
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL %s busy cyc%0d: got %b expected 1", tag, k, busy);
            end
        end
        last_addr = ea[n-1];
        if (ncheck < 0) begin
            @(posedge Clk); #1;
            checks += 2;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL %s busy_end: got %b expected 0", tag, busy);
            end
            if (rom_addr !== last_addr) begin
                errors++;
                $display("FAIL %s rom_addr_hold: got %0d expected %0d", tag, rom_addr, last_addr);
            end
        end
    endtask

    task automatic sweep(input string tag);
        logic e;
        for (int w = 0; w < 40; w++) obs_line[w] = 16'h0;
        for (int x = 0; x < 650; x++) begin
            DrawX = 10'(x);
            @(posedge Clk); #1;
            e = (x < 640 && DrawY < 10'd480) ? exp_line[x / 16][15 - (x % 16)] : 1'b0;
            if (x < 640) obs_line[x / 16][15 - (x % 16)] = plat_on;
            checks++;
            if (plat_on !== e) begin
                errors++;
                $display("FAIL %s plat_on x=%0d y=%0d: got %b expected %b", tag, x, DrawY, plat_on, e);
            end
        end
        DrawX = 10'd0;
    endtask

    // Fill line tgt_of(y), swap it onto the display, then sweep it.
    task automatic do_line(input int y, input string tag);
        int t;
        t = tgt_of(y);
        model_line(t);
        pulse_ls(y);
        check_trace(t, -1, tag);
        pulse_ls(t);
        check_trace(tgt_of(t), -1, tag);
        sweep(tag);
        $display("line %s: y=%0d target=%0d", tag, y, t);
    endtask

    task automatic check_word(input string tag, input int w, input logic [15:0] req);
        checks++;
        if (obs_line[w] !== req) begin
            errors++;
            $display("FAIL %s word%0d: got %h expected %h", tag, w, obs_line[w], req);
        end
    endtask

    task automatic clear_slots();
        for (int i = 0; i < NP; i++) begin
            p_en[i] = 1'b0; p_tx[i] = 0; p_y[i] = 0; p_len[i] = 0;
        end
    endtask

    task automatic set_fixed_rom();
        for (int c = 0; c < 3; c++) begin
            rom_mem[c*4 + 0] = 16'hFFFF;
            rom_mem[c*4 + 3] = 16'hFFFF;
        end
        rom_mem[1] = 16'h8000; rom_mem[2]  = 16'h8000;
        rom_mem[5] = 16'h0000; rom_mem[6]  = 16'h0000;
        rom_mem[9] = 16'h0001; rom_mem[10] = 16'h0001;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b0;
        last_addr = 11'd0;
    endtask

    task automatic check_idle_outputs(input string tag);
        checks += 4;
        if (plat_on !== 1'b0) begin errors++; $display("FAIL %s plat_on: got %b expected 0", tag, plat_on); end
        if (busy !== 1'b0) begin errors++; $display("FAIL %s busy: got %b expected 0", tag, busy); end
        if (rom_addr !== 11'd0) begin errors++; $display("FAIL %s rom_addr: got %0d expected 0", tag, rom_addr); end
        if (overrun !== 1'b0) begin errors++; $display("FAIL %s overrun: got %b expected 0", tag, overrun); end
    endtask

    task automatic test_reset();
        clear_slots();
        set_fixed_rom();
        line_start = 1'b0; DrawX = 10'd0; DrawY = 10'd10;
        do_reset();
        repeat (10) @(posedge Clk);
        #1;
        check_idle_outputs("reset");
        for (int w = 0; w < 40; w++) exp_line[w] = 16'h0;
        sweep("reset_buf");
        $display("test_reset done");
    endtask

    task automatic test_basic();
        clear_slots();
        p_en[0] = 1'b1; p_tx[0] = 2; p_y[0] = 100; p_len[0] = 3;
        do_line(99, "row0");
        check_word("row0", 2, 16'hFFFF);
        check_word("row0", 4, 16'hFFFF);
        check_word("row0", 1, 16'h0000);
        check_word("row0", 5, 16'h0000);
        do_line(100, "row1");
        check_word("row1", 2, 16'h8000);
        check_word("row1", 3, 16'h0000);
        check_word("row1", 4, 16'h0001);
    endtask

    task automatic test_wrap();
        clear_slots();
        p_en[0] = 1'b1; p_tx[0] = 39; p_y[0] = 0; p_len[0] = 3;
        do_line(524, "wrap");
        check_word("wrap", 39, 16'hFFFF);
        check_word("wrap", 0, 16'h0000);
    endtask

    task automatic test_overlap();
        clear_slots();
        p_en[0] = 1'b1; p_tx[0] = 5; p_y[0] = 199; p_len[0] = 3;
        p_en[1] = 1'b1; p_tx[1] = 3; p_y[1] = 198; p_len[1] = 3;
        do_line(199, "overlap");
        check_word("overlap", 5, 16'h8001);
    endtask

    task automatic test_overrun();
        clear_slots();
        for (int i = 0; i < NP; i++) begin
            p_en[i] = 1'b1; p_tx[i] = 8 * i; p_y[i] = 300; p_len[i] = 15;
        end
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_pre: got %b expected 0", overrun); end
        pulse_ls(299);
        check_trace(300, 3, "ovr_abandon");
        pulse_ls(299);
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b expected 1", overrun); end
        check_trace(300, -1, "ovr_restart");
        repeat (5) @(posedge Clk);
        #1;
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b expected 1", overrun); end
        clear_slots();
        do_reset();
        #1;
        check_idle_outputs("ovr_reset");
        $display("test_overrun done");
    endtask

    task automatic test_random();
        int y;
        for (int it = 0; it < 16; it++) begin
            for (int a = 0; a < 12; a++) rom_mem[a] = 16'($urandom);
            y = (it % 4 == 3) ? $urandom_range(479, 522) : $urandom_range(0, 478);
            for (int i = 0; i < NP; i++) begin
                p_en[i]  = ($urandom_range(0, 3) != 0);
                p_tx[i]  = (it % 5 == 4) ? $urandom_range(30, 63) : $urandom_range(0, 45);
                p_len[i] = $urandom_range(0, 15);
                p_y[i]   = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 1023)
                                                       : (y + 1 - $urandom_range(0, 5) + 1024) % 1024;
            end
            do_line(y, "random");
        end
    endtask

    initial begin
        Reset = 1'b1; line_start = 1'b0; DrawX = 10'd0; DrawY = 10'd0;
        last_addr = 11'd0;
        test_reset();
        test_basic();
        test_wrap();
        test_overlap();
        test_overrun();
        set_fixed_rom();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
